// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Covers the IF/ID word layout, the NOP encoding and the fetch FSM states.
package pipeline_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 16;
    localparam int IFID_W  = 69;

    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    localparam int INPORT_HI = 68;
    localparam int ADDR_HI   = 52;
    localparam int INSTR_HI  = 20;
    localparam int INT_BIT   = 4;

    typedef enum logic {
        RUN = 1'b0,
        INT = 1'b1
    } state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] inport;
        logic [PC_W-1:0]    addr;
        logic [INSTR_W-1:0] instr;
        logic               intf;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem port, control from decode/execute, IF/ID word out.
interface fetch_stage_if;
    import pipeline_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] in_port;
    logic               int_req;
    logic               stall;
    logic               flush;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic               idex_mem_read;
    logic [2:0]         idex_rdst;
    logic [IFID_W-1:0]  ifid_out;

    modport master (
        output imem_addr, ifid_out,
        input  imem_data, in_port, int_req, stall, flush,
        input  br_taken, br_target, idex_mem_read, idex_rdst
    );

    modport slave (
        input  imem_addr, ifid_out,
        output imem_data, in_port, int_req, stall, flush,
        output br_taken, br_target, idex_mem_read, idex_rdst
    );

endinterface

// File: rtl/fetch_stage_int_latch.sv
// Interrupt request edge detector with a sticky pending flag.
module fetch_stage_int_latch (
    input  logic Clk,
    input  logic Rst,
    input  logic int_req_i,
    input  logic clr_i,
    output logic pending_o
);

    logic req_q;
    logic pend_q, pend_d;

    // A fresh edge in the accept cycle is a new request and must survive.
    always_comb begin
        pend_d = pend_q;
        if (clr_i)
            pend_d = 1'b0;
        if (int_req_i && !req_q)
            pend_d = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            req_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            req_q  <= int_req_i;
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, redirect, stall/flush and interrupt injection.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [PC_W-1:0] INT_VECTOR = 32'h0000_0002
) (
    input logic           Clk,
    input logic           Rst,
    fetch_stage_if.master bus
);

    logic [PC_W-1:0] pc_q, pc_d;
    if_id_t          ifid_q, ifid_d;
    state_e          state_q, state_d;
    logic            int_pend;
    logic            accept;

    fetch_stage_int_latch u_int_latch (
        .Clk       (Clk),
        .Rst       (Rst),
        .int_req_i (bus.int_req),
        .clr_i     (accept),
        .pending_o (int_pend)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Leave INT once decode has consumed the injected word.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: if (accept) state_d = INT;
            INT: if (bus.br_taken || (!bus.stall && !ifid_q.intf))
                     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        accept = (state_q == RUN) && int_pend &&
                 !bus.br_taken && !bus.flush && !bus.stall;
    end

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (bus.br_taken) begin
            pc_d         = bus.br_target;
            ifid_d       = '0;
            ifid_d.instr = NOP;
        end else if (bus.flush) begin
            ifid_d       = '0;
            ifid_d.instr = NOP;
        end else if (bus.stall) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
        end else if (accept) begin
            ifid_d.inport = bus.in_port;
            ifid_d.addr   = pc_q;
            ifid_d.instr  = NOP;
            ifid_d.intf   = 1'b1;
            pc_d          = INT_VECTOR;
        end else begin
            ifid_d.inport = bus.in_port;
            ifid_d.addr   = pc_q + PC_W'(1);
            ifid_d.instr  = bus.imem_data;
            ifid_d.intf   = 1'b0;
            pc_d          = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc_q   <= RESET_PC;
            ifid_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.ifid_out[INPORT_HI:INT_BIT] = ifid_q;
    assign bus.ifid_out[INT_BIT-1:0] = {bus.idex_mem_read, bus.idex_rdst};

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a cycle-level reference model.
module tb_fetch_stage;
    import pipeline_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] IVEC   = 32'h0000_0002;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .INT_VECTOR (IVEC)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit fixed_mem = 1'b1;

    function automatic logic [15:0] mem_word(logic [31:0] a, bit fx);
        logic [15:0] v;
        v = (a[15:0] * 16'd3) ^ 16'hA5C3 ^ a[31:16];
        return fx ? 16'h1234 : v;
    endfunction

    always_comb bus.imem_data = mem_word(bus.imem_addr, fixed_mem);

    // Reference model state
    logic [31:0] m_pc;
    logic [15:0] m_inport;
    logic [31:0] m_addr;
    logic [15:0] m_instr;
    bit          m_flag;
    bit          m_pend;
    bit          m_in_int;
    bit          m_req_prev;
    int          m_accepts;

    function automatic logic [64:0] m_word();
        return {m_inport, m_addr, m_instr, m_flag};
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        m_inport = '0;
        m_addr = '0;
        m_instr = '0;
        m_flag = 1'b0;
        m_pend = 1'b0;
        m_in_int = 1'b0;
        m_req_prev = 1'b0;
    endtask

    task automatic model_clear();
        m_inport = '0;
        m_addr = '0;
        m_instr = 16'h0000;
        m_flag = 1'b0;
    endtask

    task automatic model_step();
        bit old_flag;
        bit acc;
        old_flag = m_flag;
        acc = !m_in_int && m_pend && !bus.br_taken &&
              !bus.flush && !bus.stall;
        if (bus.br_taken) begin
            m_pc = bus.br_target;
            model_clear();
        end else if (bus.flush) begin
            model_clear();
        end else if (!bus.stall) begin
            if (acc) begin
                m_inport = bus.in_port;
                m_addr = m_pc;
                m_instr = 16'h0000;
                m_flag = 1'b1;
                m_pc = IVEC;
                m_accepts++;
            end else begin
                m_inport = bus.in_port;
                m_addr = m_pc + 32'd1;
                m_instr = mem_word(m_pc, fixed_mem);
                m_flag = 1'b0;
                m_pc = m_pc + 32'd1;
            end
        end
        if (acc)
            m_in_int = 1'b1;
        else if (m_in_int && (bus.br_taken || (!bus.stall && !old_flag)))
            m_in_int = 1'b0;
        if (acc)
            m_pend = 1'b0;
        if (bus.int_req && !m_req_prev)
            m_pend = 1'b1;
        m_req_prev = bus.int_req;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_port = 16'hBEEF;
        bus.int_req = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        bus.idex_mem_read = 1'b0;
        bus.idex_rdst = 3'd0;
        Rst = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (bus.imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_pc got=%h exp=%h", bus.imem_addr, RST_PC);
        end
        checks++;
        if (bus.ifid_out[68:4] !== 65'd0) begin
            errors++;
            $display("FAIL reset_ifid got=%h exp=0", bus.ifid_out[68:4]);
        end
        Rst = 1'b1;
    endtask

    task automatic test_seq_fetch();
        fixed_mem = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (bus.imem_addr !== 32'(i)) begin
                errors++;
                $display("FAIL seq_pc got=%h exp=%h", bus.imem_addr, i);
            end
            checks++;
            if (bus.ifid_out[20:5] !== 16'h1234 ||
                bus.ifid_out[52:21] !== 32'(i) ||
                bus.ifid_out[4] !== 1'b0) begin
                errors++;
                $display("FAIL seq_ifid got=%h exp instr=1234 addr=%0d flag=0",
                         bus.ifid_out, i);
            end
        end
        repeat (2) tick();
        checks++;
        if (bus.imem_addr !== 32'd5) begin
            errors++;
            $display("FAIL seq_pc5 got=%h exp=5", bus.imem_addr);
        end
    endtask

    task automatic test_stall_flush();
        logic [64:0] held;
        held = m_word();
        bus.stall = 1'b1;
        bus.in_port = 16'h7777;
        repeat (2) begin
            tick();
            checks++;
            if (bus.imem_addr !== 32'd5 || bus.ifid_out[68:4] !== held) begin
                errors++;
                $display("FAIL stall_hold got pc=%h ifid=%h exp pc=5 ifid=%h",
                         bus.imem_addr, bus.ifid_out[68:4], held);
            end
        end
        bus.flush = 1'b1;
        tick();
        checks++;
        if (bus.ifid_out[20:5] !== 16'h0000 || bus.ifid_out[4] !== 1'b0 ||
            bus.imem_addr !== 32'd5) begin
            errors++;
            $display("FAIL flush got instr=%h flag=%b pc=%h exp 0/0/5",
                     bus.ifid_out[20:5], bus.ifid_out[4], bus.imem_addr);
        end
        bus.flush = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_branch_int();
        bus.stall = 1'b1;
        bus.br_taken = 1'b1;
        bus.br_target = 32'h40;
        bus.int_req = 1'b1;
        tick();
        checks++;
        if (bus.imem_addr !== 32'h40 || bus.ifid_out[20:4] !== 17'd0) begin
            errors++;
            $display("FAIL br_redirect got pc=%h instr+flag=%h exp 40/0",
                     bus.imem_addr, bus.ifid_out[20:4]);
        end
        bus.stall = 1'b0;
        bus.br_taken = 1'b0;
        tick();
        checks++;
        if (bus.ifid_out[4] !== 1'b1 || bus.ifid_out[52:21] !== 32'h40 ||
            bus.imem_addr !== IVEC) begin
            errors++;
            $display("FAIL br_int_accept got flag=%b addr=%h pc=%h exp 1/40/%h",
                     bus.ifid_out[4], bus.ifid_out[52:21], bus.imem_addr, IVEC);
        end
        bus.int_req = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.imem_addr !== m_pc || bus.ifid_out[68:4] !== m_word()) begin
            errors++;
            $display("FAIL br_int_resume got pc=%h ifid=%h exp pc=%h ifid=%h",
                     bus.imem_addr, bus.ifid_out[68:4], m_pc, m_word());
        end
    endtask

    task automatic test_int_hold();
        int seen;
        seen = 0;
        bus.br_taken = 1'b1;
        bus.br_target = 32'd7;
        bus.int_req = 1'b1;
        tick();
        bus.br_taken = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.ifid_out[4] === 1'b1) begin
                seen++;
                checks++;
                if (bus.ifid_out[52:21] !== 32'd7 || bus.imem_addr !== IVEC) begin
                    errors++;
                    $display("FAIL hold_accept got addr=%h pc=%h exp 7/%h",
                             bus.ifid_out[52:21], bus.imem_addr, IVEC);
                end
            end
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL hold_count got=%0d exp=1", seen);
        end
        bus.int_req = 1'b0;
        tick();
        bus.int_req = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.ifid_out[4] !== 1'b1 || bus.imem_addr !== IVEC) begin
            errors++;
            $display("FAIL defer_first got flag=%b pc=%h exp 1/%h",
                     bus.ifid_out[4], bus.imem_addr, IVEC);
        end
        bus.stall = 1'b1;
        bus.int_req = 1'b0;
        tick();
        bus.int_req = 1'b1;
        tick();
        bus.stall = 1'b0;
        tick();
        checks++;
        if (bus.ifid_out[4] !== 1'b0 || bus.imem_addr !== 32'd3) begin
            errors++;
            $display("FAIL defer_blocked got flag=%b pc=%h exp 0/3",
                     bus.ifid_out[4], bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.ifid_out[4] !== 1'b0 || bus.imem_addr !== 32'd4) begin
            errors++;
            $display("FAIL defer_run got flag=%b pc=%h exp 0/4",
                     bus.ifid_out[4], bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.ifid_out[4] !== 1'b1 || bus.ifid_out[52:21] !== 32'd4 ||
            bus.imem_addr !== IVEC) begin
            errors++;
            $display("FAIL defer_accept got flag=%b addr=%h pc=%h exp 1/4/%h",
                     bus.ifid_out[4], bus.ifid_out[52:21], bus.imem_addr, IVEC);
        end
        bus.int_req = 1'b0;
    endtask

    task automatic test_wrap();
        bus.br_taken = 1'b1;
        bus.br_target = 32'hFFFF_FFFF;
        tick();
        bus.br_taken = 1'b0;
        tick();
        checks++;
        if (bus.imem_addr !== 32'd0 || bus.ifid_out[52:21] !== 32'd0) begin
            errors++;
            $display("FAIL wrap got pc=%h addr=%h exp 0/0",
                     bus.imem_addr, bus.ifid_out[52:21]);
        end
    endtask

    task automatic test_passthru();
        #2;
        bus.idex_mem_read = 1'b1;
        bus.idex_rdst = 3'b101;
        #1;
        checks++;
        if (bus.ifid_out[3:0] !== 4'b1101) begin
            errors++;
            $display("FAIL pass_a got=%b exp=1101", bus.ifid_out[3:0]);
        end
        bus.idex_mem_read = 1'b0;
        bus.idex_rdst = 3'b010;
        #1;
        checks++;
        if (bus.ifid_out[3:0] !== 4'b0010) begin
            errors++;
            $display("FAIL pass_b got=%b exp=0010", bus.ifid_out[3:0]);
        end
        bus.idex_rdst = 3'b000;
    endtask

    task automatic test_async_reset();
        tick();
        bus.int_req = 1'b1;
        bus.in_port = 16'hC0DE;
        tick();
        tick();
        checks++;
        if (bus.ifid_out[4] !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got flag=%b exp=1", bus.ifid_out[4]);
        end
        #2;
        Rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.imem_addr !== RST_PC || bus.ifid_out[68:4] !== 65'd0) begin
            errors++;
            $display("FAIL areset got pc=%h ifid=%h exp %h/0",
                     bus.imem_addr, bus.ifid_out[68:4], RST_PC);
        end
        #2;
        Rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.ifid_out[4] !== 1'b1 || bus.ifid_out[52:21] !== 32'd1) begin
            errors++;
            $display("FAIL areset_run got flag=%b addr=%h exp 1/1",
                     bus.ifid_out[4], bus.ifid_out[52:21]);
        end
        bus.int_req = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] targets [4];
        targets[0] = 32'hFFFF_FFFE;
        targets[1] = 32'h0000_0010;
        targets[2] = 32'h8000_0000;
        targets[3] = 32'h0000_0002;
        fixed_mem = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.br_taken = ($urandom_range(0, 9) == 0);
            bus.flush = ($urandom_range(0, 11) == 0);
            bus.stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0)
                bus.int_req = ~bus.int_req;
            bus.in_port = 16'($urandom);
            bus.br_target = ($urandom_range(0, 1) == 0) ?
                            targets[$urandom_range(0, 3)] : $urandom;
            bus.idex_mem_read = 1'($urandom);
            bus.idex_rdst = 3'($urandom);
            tick();
            checks++;
            if (bus.imem_addr !== m_pc || bus.ifid_out[68:4] !== m_word() ||
                bus.ifid_out[3:0] !== {bus.idex_mem_read, bus.idex_rdst}) begin
                errors++;
                $display("FAIL rand[%0d] got pc=%h ifid=%h exp pc=%h ifid=%h",
                         i, bus.imem_addr, bus.ifid_out, m_pc, m_word());
            end
        end
        checks++;
        if (m_accepts < 3) begin
            errors++;
            $display("FAIL rand_accepts got=%0d exp>=3", m_accepts);
        end
    endtask

    initial begin
        m_accepts = 0;
        test_reset();
        test_seq_fetch();
        test_stall_flush();
        test_branch_int();
        test_int_hold();
        test_wrap();
        test_passthru();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage.
- Owns the PC and the instruction-memory address, and packs the 69-bit IF/ID word that decode consumes.
- Honours decode's stall and flush requests, and execute's branch redirect.
- Latches external interrupts and injects them into the pipeline with the correct return address.

Parameters:
- PC_W, 32: program-counter width.
- INSTR_W, 16: instruction word width.
- RESET_PC, 32'h0000_0000: PC value after reset.
- INT_VECTOR, 32'h0000_0002: PC loaded when an interrupt is accepted.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- imem_addr  out  32  instruction-memory address; combinational, equal to PC.
- imem_data  in  16  instruction word; asynchronous read of imem_addr.
- in_port  in  16  external input port value.
- int_req  in  1  external interrupt request (level).
- stall  in  1  decode stall request: hold PC and IF/ID.
- flush  in  1  decode flush request: clear IF/ID to NOP.
- br_taken  in  1  execute branch/jump taken.
- br_target  in  32  redirect PC.
- idex_mem_read  in  1  ID/EX memory-read flag.
- idex_rdst  in  3  ID/EX destination register.
- ifid_out  out  69  IF/ID word with this packing:
  - [68:53] in_port (registered)
  - [52:21] address (registered)
  - [20:5] instruction (registered)
  - [4] interrupt flag (registered)
  - [3] idex_mem_read (combinational pass-through)
  - [2:0] idex_rdst (combinational pass-through)

Behaviour:
- Reset (Rst=0, asynchronous):
  - PC=RESET_PC.
  - Registered fields of ifid_out = 0, so the instruction is NOP (16'h0000).
  - int_pending=0, int_req_d=0, state=RUN.
  - Reset mid-interrupt abandons the interrupt entirely.
- Interrupt latch:
  - int_pending sets on a rising edge of int_req (int_req & ~int_req_d) and clears only on acceptance.
  - A held int_req level does not re-trigger.
- Per-edge priority, highest first:
  1. br_taken:
     - PC<=br_target.
     - IF/ID cleared to NOP, flag 0.
     - Overrides stall and flush.
     - An interrupt pending in the same cycle stays pending.
  2. flush:
     - IF/ID cleared to NOP, flag 0.
     - PC holds.
  3. stall:
     - PC, IF/ID and state all hold.
     - int_pending may still set.
  4. Interrupt accept (state RUN and int_pending):
     - IF/ID <= {in_port, PC, 16'h0000, 1'b1}; PC is the return address, not yet fetched.
     - PC<=INT_VECTOR.
     - int_pending<=0.
     - state<=INT.
  5. Normal fetch:
     - IF/ID <= {in_port, PC+1, imem_data, 1'b0}.
     - PC<=PC+1.
- FSM, states RUN and INT:
  - INT blocks further interrupt acceptance; new edges stay pending.
  - Fetch proceeds normally in INT (handler code).
  - INT->RUN on the first edge where stall=0 and the IF/ID interrupt flag is 0, i.e. once decode has finished its multi-cycle push sequence.
  - br_taken in INT also returns to RUN.
- Latency: one cycle from imem_data to ifid_out.
- Arithmetic: PC+1 is modulo 2^32, so 32'hFFFF_FFFF wraps to 0. No other arithmetic.
- Pass-throughs: ifid_out[3:0] follow idex_mem_read/idex_rdst combinationally with zero latency. Decode's load-use detector depends on this.

Decomposition:
- Shared package (pipeline_pkg):
  - NOP encoding 16'h0000.
  - IF/ID field offsets (INPORT_HI=68, ADDR_HI=52, INSTR_HI=20, INT_BIT=4).
  - State encoding RUN=1'b0, INT=1'b1.
  - Width constants PC_W, INSTR_W.
- One natural sub-module: int_latch, holding the edge detector plus the pending flag with set/clear ports. The PC/IF-ID logic stays in fetch_stage.

Test Plan:
- Reset then 3 clocks, imem_data=16'h1234 at each address → PC goes 0,1,2,3; ifid_out[20:5]=16'h1234, [52:21]=1,2,3; flag 0.
- stall=1 for 2 cycles at PC=5 → PC stays 5 and ifid_out is unchanged. Then flush=1 with stall=1 → instruction field 16'h0000, PC 5.
- br_taken=1, br_target=32'h40, with stall=1 and an int_req edge in the same cycle → PC=32'h40, IF/ID NOP. Interrupt accepted on the next unstalled edge: [52:21]=32'h40, flag 1, PC=INT_VECTOR.
- int_req held high 10 cycles at PC=7 → exactly one accept: ifid_out[4]=1, [52:21]=7, PC=2. A second int_req edge while in INT is deferred until the FSM returns to RUN.
- PC=32'hFFFF_FFFF, normal fetch → PC=0, ifid_out[52:21]=0.
- idex_mem_read=1, idex_rdst=3'b101 toggled mid-cycle → ifid_out[3:0]=4'b1101 in the same cycle. Rst=0 during INT → all registered fields 0 and state RUN, asynchronously.
